dw_cluster_feeder: RTL
======================

Name: dw_cluster_feeder

Overview:
- Sequencer and initiator for the 4-lane depthwise PE cluster.
- Loads one kernel of packed 4-lane weights into a local register file, then streams one IFM word per tap per window.
- Frames each window with PE_reset and PE_finish, captures OFM_0..3 and returns them on a valid/ready output stream.
- Sits between the line/weight buffers and the cluster.

Parameters:
- MAX_TAPS, 9, maximum kernel taps per window (3x3); sets weight RF depth.
- WIN_W, 16, width of the window counter.
- PE_LATENCY, 2, cycles from the cluster-side PE_finish cycle to valid OFM_0..3.

Ports:
- clk  in  1  clock
- reset_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle job start, honoured only in IDLE
- cfg_num_taps  in  4  taps per window, legal 1..MAX_TAPS
- cfg_num_windows  in  WIN_W  windows per job, legal >=1
- weight_valid / weight_ready  in / out  1  weight stream handshake
- weight_data  in  32  packed weights, lane0 = [31:24] .. lane3 = [7:0]
- ifm_valid / ifm_ready  in / out  1  IFM stream handshake
- ifm_data  in  32  packed IFM bytes, same lane order
- IFM  out  32  to cluster
- Weight_0..Weight_3  out  8 each  to cluster lanes 0..3
- PE_reset  out  1  accumulator clear to cluster
- PE_finish  out  1  end-of-window to cluster
- OFM_0..OFM_3  in  8 each  from cluster
- ofm_valid / ofm_ready  out / in  1  result stream handshake
- ofm_data  out  32  {OFM_0, OFM_1, OFM_2, OFM_3}
- busy  out  1  high whenever state != IDLE
- done  out  1  one-cycle pulse at job end
- cfg_err  out  1  one-cycle pulse on an illegal start

Behaviour:
- Reset: every output is 0, state is IDLE, counters and weight RF are cleared. Reset asserted mid-job aborts the job with no done pulse.
- All cluster-side outputs are registered. Data accepted by a handshake in cycle t is presented to the cluster in cycle t+1.
- Whenever no tap is issued, IFM and Weight_0..3 are driven to 0, so the cluster MAC adds zero during stalls.
- IDLE:
  - start with legal cfg: latch cfg, go to LOAD_W.
  - start with illegal cfg (taps 0 or >MAX_TAPS, windows 0): cfg_err pulses, stay in IDLE.
  - start while busy: ignored.
- LOAD_W: weight_ready=1. Each handshake writes RF[tap_cnt]. After cfg_num_taps words, go to CLEAR.
- CLEAR: PE_reset=1 for exactly one cycle, tap_cnt=0, then go to FEED.
- FEED:
  - ifm_ready=1.
  - Each handshake drives IFM=ifm_data and Weight_i = byte i of RF[tap_cnt] on the next cycle, then increments tap_cnt.
  - On the last tap's handshake, PE_finish=1 in the same registered cycle as the last tap data. Then go to WAIT_OFM.
  - ifm_valid gaps stall FEED indefinitely with zero-data cycles.
- WAIT_OFM: counts PE_LATENCY cycles after the PE_finish cycle, then registers OFM_0..3 into ofm_data, sets ofm_valid, and goes to OUT.
- OUT:
  - ofm_valid and ofm_data are held stable until ofm_ready.
  - On handshake: if windows remain, go to CLEAR; otherwise pulse done and go to IDLE.
  - ofm_valid and ofm_ready high in the same cycle complete the transfer.
- Weights load once per job and are reused by every window.
- Single-tap window: PE_finish coincides with the only tap.
- cfg inputs are not sampled after start.

Optional Feature:
- Macro DW_FEEDER_PERF_CNT_EN.
- Defined: adds outputs stall_cycles[31:0] and job_cycles[31:0].
  - stall_cycles counts FEED cycles with ifm_valid=0 plus OUT cycles with ofm_ready=0.
  - job_cycles counts every busy cycle.
  - Both clear on an accepted start; both hold after done.
- Not defined: ports and counters are absent; all other behaviour is identical.

Decomposition:
- Package dw_pkg holds:
  - the state enum (IDLE, LOAD_W, CLEAR, FEED, WAIT_OFM, OUT);
  - LANES=4 and the lane byte-slice constants;
  - the packed-word typedef of 4 x 8-bit lanes.
- One sub-module, dw_weight_rf: MAX_TAPS x 32 register file with sync write, combinational read and async clear.

Test Plan:
- taps=9, windows=1, all weights 0x01010101, IFM 0x01020304 for every tap, stub cluster MAC -> PE_reset one cycle before the first tap, PE_finish with tap 9, ofm_data=0x09121B24, done pulse after the handshake.
- taps=4, windows=3, ofm_ready always 1 -> weight_ready high only during the first 4 handshakes; exactly 3 ofm beats; 3 PE_reset pulses.
- ifm_valid toggled every other cycle -> IFM/Weight outputs are 0 on stall cycles and the result is unchanged from the no-stall run.
- ofm_ready held low 5 cycles -> ofm_data stable, no new PE_reset until the handshake.
- start with taps=0, then taps=10 -> cfg_err pulses, busy stays 0; start pulsed during FEED -> ignored.
- reset_n low in FEED -> all outputs 0, state IDLE, no done; a new job after release completes correctly.

Source files
------------

// File: rtl/dw_pkg.sv
// Shared types and constants for the depthwise cluster feeder.
// Lane order in every packed 32-bit word: lane0 = [31:24] .. lane3 = [7:0].
package dw_pkg;

    localparam int LANES  = 4;
    localparam int LANE_W = 8;
    localparam int WORD_W = LANES * LANE_W;

    // Index of each lane inside word_t (element [3] holds bits [31:24]).
    localparam logic [1:0] LANE0 = 2'd3;
    localparam logic [1:0] LANE1 = 2'd2;
    localparam logic [1:0] LANE2 = 2'd1;
    localparam logic [1:0] LANE3 = 2'd0;

    typedef logic [LANES-1:0][LANE_W-1:0] word_t;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        LOAD_W   = 3'd1,
        CLEAR    = 3'd2,
        FEED     = 3'd3,
        WAIT_OFM = 3'd4,
        OUT      = 3'd5
    } state_t;

endpackage

// File: rtl/dw_cluster_feeder_if.sv
// Stream bundle between the line/weight buffers and the feeder.
// Handshake rule for all three streams: a beat transfers on a rising clock
// edge where valid and ready are both high; the source holds valid and data
// stable until that edge, and valid never waits on ready.
interface dw_cluster_feeder_if;
    import dw_pkg::*;

    logic  weight_valid;
    logic  weight_ready;
    word_t weight_data;
    logic  ifm_valid;
    logic  ifm_ready;
    word_t ifm_data;
    logic  ofm_valid;
    logic  ofm_ready;
    word_t ofm_data;

    // Buffer side: sources weights and IFM, sinks results.
    modport master (
        output weight_valid, weight_data, ifm_valid, ifm_data, ofm_ready,
        input  weight_ready, ifm_ready, ofm_valid, ofm_data
    );

    // Feeder side.
    modport slave (
        input  weight_valid, weight_data, ifm_valid, ifm_data, ofm_ready,
        output weight_ready, ifm_ready, ofm_valid, ofm_data
    );

endinterface

// File: rtl/dw_weight_rf.sv
// Kernel weight register file: synchronous write, combinational read,
// asynchronous clear. Out-of-range reads return zero.
module dw_weight_rf
    import dw_pkg::*;
#(
    parameter int DEPTH = 9,
    parameter int AW    = 4
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  word_t         wdata,
    input  logic [AW-1:0] raddr,
    output word_t         rdata
);

    word_t mem_q [DEPTH];
    word_t mem_d [DEPTH];

    // Next-state of the array: only the addressed entry changes on a write.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            mem_d[i] = mem_q[i];
        end
        if (we && (waddr < AW'(DEPTH))) begin
            mem_d[waddr] = wdata;
        end
    end

    // Storage with asynchronous clear.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= mem_d[i];
            end
        end
    end

    // Combinational read port.
    always_comb begin
        rdata = '0;
        if (raddr < AW'(DEPTH)) begin
            rdata = mem_q[raddr];
        end
    end

endmodule

// File: rtl/dw_cluster_feeder.sv
// Sequencer for the 4-lane depthwise PE cluster: loads one kernel of weights,
// streams one IFM word per tap per window framed by PE_reset/PE_finish, and
// returns OFM_0..3 on the result stream. All cluster-side outputs are flops.
// Optional build macro DW_FEEDER_PERF_CNT_EN adds stall_cycles/job_cycles.
module dw_cluster_feeder
    import dw_pkg::*;
#(
    parameter int MAX_TAPS   = 9,
    parameter int WIN_W      = 16,
    parameter int PE_LATENCY = 2
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   start,
    input  logic [3:0]             cfg_num_taps,
    input  logic [WIN_W-1:0]       cfg_num_windows,
    dw_cluster_feeder_if.slave     bus,
    output logic [31:0]            IFM,
    output logic [7:0]             Weight_0,
    output logic [7:0]             Weight_1,
    output logic [7:0]             Weight_2,
    output logic [7:0]             Weight_3,
    output logic                   PE_reset,
    output logic                   PE_finish,
    input  logic [7:0]             OFM_0,
    input  logic [7:0]             OFM_1,
    input  logic [7:0]             OFM_2,
    input  logic [7:0]             OFM_3,
    output logic                   busy,
    output logic                   done,
    output logic                   cfg_err,
    output state_t                 dbg_state
`ifdef DW_FEEDER_PERF_CNT_EN
    ,
    output logic [31:0]            stall_cycles,
    output logic [31:0]            job_cycles
`endif
);

    state_t           state_q, state_d;
    logic [3:0]       taps_q, taps_d;
    logic [WIN_W-1:0] wins_q, wins_d;
    logic [3:0]       tap_cnt_q, tap_cnt_d;
    logic [WIN_W-1:0] win_cnt_q, win_cnt_d;
    logic [7:0]       lat_cnt_q, lat_cnt_d;
    word_t            ifm_q, ifm_d;
    word_t            w_q, w_d;
    word_t            ofm_data_q, ofm_data_d;
    logic             ofm_valid_q, ofm_valid_d;
    logic             pe_reset_q, pe_reset_d;
    logic             pe_finish_q, pe_finish_d;
    logic             done_q, done_d;
    logic             cfg_err_q, cfg_err_d;

    logic             rf_we;
    word_t            rf_rdata;
    logic             cfg_ok;
    logic             last_tap;
    logic             w_hs;
    logic             ifm_hs;

    assign cfg_ok   = (cfg_num_taps != 4'd0) && (cfg_num_taps <= 4'(MAX_TAPS)) &&
                      (cfg_num_windows != '0);
    assign last_tap = (tap_cnt_q == (taps_q - 4'd1));
    assign w_hs     = bus.weight_valid && (state_q == LOAD_W);
    assign ifm_hs   = bus.ifm_valid && (state_q == FEED);

    dw_weight_rf #(.DEPTH(MAX_TAPS), .AW(4)) u_rf (
        .clk     (clk),
        .reset_n (reset_n),
        .we      (rf_we),
        .waddr   (tap_cnt_q),
        .wdata   (bus.weight_data),
        .raddr   (tap_cnt_q),
        .rdata   (rf_rdata)
    );

    // Next-state and registered-output logic; tap data defaults to zero so
    // the cluster accumulates nothing on cycles without a tap.
    always_comb begin
        state_d     = state_q;
        taps_d      = taps_q;
        wins_d      = wins_q;
        tap_cnt_d   = tap_cnt_q;
        win_cnt_d   = win_cnt_q;
        lat_cnt_d   = lat_cnt_q;
        ifm_d       = '0;
        w_d         = '0;
        ofm_data_d  = ofm_data_q;
        ofm_valid_d = ofm_valid_q;
        pe_reset_d  = 1'b0;
        pe_finish_d = 1'b0;
        done_d      = 1'b0;
        cfg_err_d   = 1'b0;
        rf_we       = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    if (cfg_ok) begin
                        taps_d    = cfg_num_taps;
                        wins_d    = cfg_num_windows;
                        tap_cnt_d = 4'd0;
                        win_cnt_d = '0;
                        state_d   = LOAD_W;
                    end else begin
                        cfg_err_d = 1'b1;
                    end
                end
            end
            LOAD_W: begin
                if (w_hs) begin
                    rf_we = 1'b1;
                    if (last_tap) begin
                        tap_cnt_d = 4'd0;
                        state_d   = CLEAR;
                    end else begin
                        tap_cnt_d = tap_cnt_q + 4'd1;
                    end
                end
            end
            CLEAR: begin
                pe_reset_d = 1'b1;
                tap_cnt_d  = 4'd0;
                state_d    = FEED;
            end
            FEED: begin
                if (ifm_hs) begin
                    ifm_d = bus.ifm_data;
                    w_d   = rf_rdata;
                    if (last_tap) begin
                        pe_finish_d = 1'b1;
                        lat_cnt_d   = 8'd0;
                        state_d     = WAIT_OFM;
                    end else begin
                        tap_cnt_d = tap_cnt_q + 4'd1;
                    end
                end
            end
            WAIT_OFM: begin
                // First WAIT_OFM cycle is the cycle PE_finish is on the wire.
                if (lat_cnt_q == 8'(PE_LATENCY)) begin
                    ofm_data_d  = {OFM_0, OFM_1, OFM_2, OFM_3};
                    ofm_valid_d = 1'b1;
                    state_d     = OUT;
                end else begin
                    lat_cnt_d = lat_cnt_q + 8'd1;
                end
            end
            OUT: begin
                if (bus.ofm_ready) begin
                    ofm_valid_d = 1'b0;
                    if (win_cnt_q == (wins_q - WIN_W'(1))) begin
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end else begin
                        win_cnt_d = win_cnt_q + WIN_W'(1);
                        state_d   = CLEAR;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, counters and registered outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            taps_q      <= '0;
            wins_q      <= '0;
            tap_cnt_q   <= '0;
            win_cnt_q   <= '0;
            lat_cnt_q   <= '0;
            ifm_q       <= '0;
            w_q         <= '0;
            ofm_data_q  <= '0;
            ofm_valid_q <= 1'b0;
            pe_reset_q  <= 1'b0;
            pe_finish_q <= 1'b0;
            done_q      <= 1'b0;
            cfg_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            taps_q      <= taps_d;
            wins_q      <= wins_d;
            tap_cnt_q   <= tap_cnt_d;
            win_cnt_q   <= win_cnt_d;
            lat_cnt_q   <= lat_cnt_d;
            ifm_q       <= ifm_d;
            w_q         <= w_d;
            ofm_data_q  <= ofm_data_d;
            ofm_valid_q <= ofm_valid_d;
            pe_reset_q  <= pe_reset_d;
            pe_finish_q <= pe_finish_d;
            done_q      <= done_d;
            cfg_err_q   <= cfg_err_d;
        end
    end

    assign IFM              = ifm_q;
    assign Weight_0         = w_q[LANE0];
    assign Weight_1         = w_q[LANE1];
    assign Weight_2         = w_q[LANE2];
    assign Weight_3         = w_q[LANE3];
    assign PE_reset         = pe_reset_q;
    assign PE_finish        = pe_finish_q;
    assign bus.weight_ready = (state_q == LOAD_W);
    assign bus.ifm_ready    = (state_q == FEED);
    assign bus.ofm_valid    = ofm_valid_q;
    assign bus.ofm_data     = ofm_data_q;
    assign busy             = (state_q != IDLE);
    assign done             = done_q;
    assign cfg_err          = cfg_err_q;
    assign dbg_state        = state_q;

`ifdef DW_FEEDER_PERF_CNT_EN
    logic [31:0] stall_q, stall_d;
    logic [31:0] job_q, job_d;

    // Counters restart on an accepted start and freeze once back in IDLE.
    always_comb begin
        stall_d = stall_q;
        job_d   = job_q;
        if (state_q == IDLE) begin
            if (start && cfg_ok) begin
                stall_d = '0;
                job_d   = '0;
            end
        end else begin
            job_d = job_q + 32'd1;
            if (((state_q == FEED) && !bus.ifm_valid) ||
                ((state_q == OUT) && !bus.ofm_ready)) begin
                stall_d = stall_q + 32'd1;
            end
        end
    end

    // Performance counter registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stall_q <= '0;
            job_q   <= '0;
        end else begin
            stall_q <= stall_d;
            job_q   <= job_d;
        end
    end

    assign stall_cycles = stall_q;
    assign job_cycles   = job_q;
`endif

endmodule
